// File: rtl/ncl_fullword_counter_sync.sv
// ncl_fullword_counter_sync
//   Clocked WIDTH-bit counter that presents its value as a dual-rail word
//   under a 4-phase full-word-completeness handshake. Each count value is
//   sent as a DATA wavefront (cnt_t=count, cnt_f=~count, carry pair valid,
//   comp_out=1) followed by NULL (all rails 0, comp_out=0). The count
//   advances by STEP, up or down, once per completed DATA+NULL cycle, either
//   wrapping or saturating.
//
// Ports
//   clk       in   1      clock, all state on rising edge
//   init_n    in   1      synchronous reset, active low
//   en        in   1      1 = permit the next DATA wavefront
//   dir       in   1      1 = up, 0 = down; latched on NULL->DATA
//   ack_comp  in   1      consumer completeness: 0 = wants DATA, 1 = wants NULL
//   cnt_t     out  WIDTH  rail-1 of the count word
//   cnt_f     out  WIDTH  rail-0 of the count word
//   carry_t   out  1      rail-1 of the terminal carry
//   carry_f   out  1      rail-0 of the terminal carry
//   comp_out  out  1      1 iff the whole word (and carry) is DATA
module ncl_fullword_counter_sync #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      STEP       = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  parameter int unsigned      SATURATE   = 0
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic             en,
  input  logic             dir,
  input  logic             ack_comp,
  output logic [WIDTH-1:0] cnt_t,
  output logic [WIDTH-1:0] cnt_f,
  output logic             carry_t,
  output logic             carry_f,
  output logic             comp_out
);

  typedef enum logic {
    S_NULL,
    S_DATA
  } state_t;

  // Step widened by one bit so the up-count carry falls out of the adder.
  localparam logic [WIDTH:0] STEP_X = (WIDTH + 1)'(STEP);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             dir_l;
  logic [WIDTH:0]   sum_up;
  logic [WIDTH-1:0] diff_dn;
  logic             carry;

  // Arithmetic on the presented value with the direction latched at DATA
  // entry, so the carry shown during DATA matches the value committed later.
  always_comb begin
    sum_up  = {1'b0, count} + STEP_X;
    diff_dn = count - STEP_X[WIDTH-1:0];
    if (dir_l) begin
      carry      = sum_up[WIDTH];
      count_next = ((SATURATE != 0) && carry) ? '1 : sum_up[WIDTH-1:0];
    end else begin
      carry      = ({1'b0, count} < STEP_X);
      count_next = ((SATURATE != 0) && carry) ? '0 : diff_dn;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state <= S_NULL;
    end else begin
      state <= state_next;
    end
  end

  // Count and latched direction
  always_ff @(posedge clk) begin
    if (!init_n) begin
      count <= INIT_VALUE;
      dir_l <= 1'b1;
    end else begin
      if (state == S_NULL && state_next == S_DATA) begin
        dir_l <= dir;
      end
      // Count commits on the DATA->NULL edge, after the consumer accepted it.
      if (state == S_DATA && ack_comp) begin
        count <= count_next;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      S_NULL: if (en && !ack_comp) state_next = S_DATA;
      S_DATA: if (ack_comp)        state_next = S_NULL;
      default:                     state_next = S_NULL;
    endcase
  end

  // Outputs are decoded from registered state only, so every rail changes
  // on the same clock edge and no mixed DATA/NULL word can appear.
  always_comb begin
    cnt_t    = '0;
    cnt_f    = '0;
    carry_t  = 1'b0;
    carry_f  = 1'b0;
    comp_out = 1'b0;
    if (state == S_DATA) begin
      cnt_t    = count;
      cnt_f    = ~count;
      carry_t  = carry;
      carry_f  = ~carry;
      comp_out = 1'b1;
    end
  end

endmodule

// File: tb/tb_ncl_fullword_counter_sync.sv
// Bench for ncl_fullword_counter_sync: three 8-bit instances sharing the
// handshake inputs (wrap up from 0, wrap up from FE, saturating down by 2
// from 01). A table of input/expected records is applied one clock per row;
// each expectation goes into a scoreboard queue when driven and is popped
// and compared when the outputs are sampled on the falling edge.
module tb_ncl_fullword_counter_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            init_n;
  logic            en;
  logic            ack_comp;
  logic            dir0;
  logic            dir1;
  logic            dir2;
  logic [2:0][7:0] cnt_t;
  logic [2:0][7:0] cnt_f;
  logic [2:0]      carry_t;
  logic [2:0]      carry_f;
  logic [2:0]      comp;

  ncl_fullword_counter_sync #(.WIDTH(8), .STEP(1), .INIT_VALUE(8'h00), .SATURATE(0)) dut0 (
    .clk(clk), .init_n(init_n), .en(en), .dir(dir0), .ack_comp(ack_comp),
    .cnt_t(cnt_t[0]), .cnt_f(cnt_f[0]), .carry_t(carry_t[0]), .carry_f(carry_f[0]),
    .comp_out(comp[0])
  );

  ncl_fullword_counter_sync #(.WIDTH(8), .STEP(1), .INIT_VALUE(8'hFE), .SATURATE(0)) dut1 (
    .clk(clk), .init_n(init_n), .en(en), .dir(dir1), .ack_comp(ack_comp),
    .cnt_t(cnt_t[1]), .cnt_f(cnt_f[1]), .carry_t(carry_t[1]), .carry_f(carry_f[1]),
    .comp_out(comp[1])
  );

  ncl_fullword_counter_sync #(.WIDTH(8), .STEP(2), .INIT_VALUE(8'h01), .SATURATE(1)) dut2 (
    .clk(clk), .init_n(init_n), .en(en), .dir(dir2), .ack_comp(ack_comp),
    .cnt_t(cnt_t[2]), .cnt_f(cnt_f[2]), .carry_t(carry_t[2]), .carry_f(carry_f[2]),
    .comp_out(comp[2])
  );

  typedef struct packed {
    logic            init_n;
    logic            en;
    logic            ack;
    logic            dir;
    logic            comp;
    logic [2:0][7:0] v;
    logic [2:0]      c;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic i, input logic e, input logic a, input logic d,
                              input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                              input logic c0, input logic c1, input logic c2);
    vec_t r;
    r.init_n = i;
    r.en     = e;
    r.ack    = a;
    r.dir    = d;
    r.comp   = 1'b1;
    r.v[0]   = v0;
    r.v[1]   = v1;
    r.v[2]   = v2;
    r.c      = {c2, c1, c0};
    tbl.push_back(r);
  endfunction

  function automatic void add_null(input logic i, input logic e, input logic a, input logic d);
    vec_t r;
    r        = '0;
    r.init_n = i;
    r.en     = e;
    r.ack    = a;
    r.dir    = d;
    tbl.push_back(r);
  endfunction

  task automatic check_outputs();
    vec_t        e;
    logic [18:0] act;
    logic [18:0] exp;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sbq.pop_front();
    for (int unsigned i = 0; i < 3; i++) begin
      act = {comp[i], carry_t[i], carry_f[i], cnt_t[i], cnt_f[i]};
      exp = e.comp ? {1'b1, e.c[i], ~e.c[i], e.v[i], ~e.v[i]} : '0;
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL word dut%0d at %0t: got {comp,ct,cf,t,f}=%h expected %h", i, $time, act, exp);
      end
      checks++;
      if ((cnt_t[i] & cnt_f[i]) != 8'h00 || (carry_t[i] & carry_f[i]) ||
          comp[i] != (&(cnt_t[i] | cnt_f[i]))) begin
        errors++;
        $display("FAIL invariant dut%0d at %0t: t=%h f=%h ct=%b cf=%b comp=%b required no double rail and comp==full word",
                 i, $time, cnt_t[i], cnt_f[i], carry_t[i], carry_f[i], comp[i]);
      end
    end
  endtask

  task automatic apply(input vec_t v);
    init_n   = v.init_n;
    en       = v.en;
    ack_comp = v.ack;
    dir0     = v.dir;
    sbq.push_back(v);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    vec_t        r;
    int unsigned n;

    init_n   = 1'b0;
    en       = 1'b0;
    ack_comp = 1'b0;
    dir0     = 1'b1;
    dir1     = 1'b1;
    dir2     = 1'b0;

    // reset
    add_null(0, 0, 0, 1);
    // basic handshake: 0,1,2,3 / FE,FF,00,01 / 01 then clamped 00
    add     (1, 1, 0, 1, 8'h00, 8'hFE, 8'h01, 0, 0, 1);
    add_null(1, 1, 1, 1);
    add     (1, 1, 0, 1, 8'h01, 8'hFF, 8'h00, 0, 1, 1);
    add_null(1, 1, 1, 1);
    add     (1, 1, 0, 1, 8'h02, 8'h00, 8'h00, 0, 0, 1);
    add_null(1, 1, 1, 1);
    add     (1, 1, 0, 1, 8'h03, 8'h01, 8'h00, 0, 0, 1);
    add_null(1, 1, 1, 1);
    // DATA entered counting up, then held 10 cycles while en/dir toggle
    add     (1, 1, 0, 1, 8'h04, 8'h02, 8'h00, 0, 0, 1);
    for (int unsigned k = 0; k < 10; k++) begin
      add(1, k[0], 0, ~k[0], 8'h04, 8'h02, 8'h00, 0, 0, 1);
    end
    // release with dir=0: advance must still be up
    add_null(1, 0, 1, 0);
    // en low in NULL: nothing appears
    for (int unsigned k = 0; k < 4; k++) add_null(1, 0, 0, 0);
    add     (1, 1, 0, 1, 8'h05, 8'h03, 8'h00, 0, 0, 1);
    // reset mid-DATA at count 5, ack held high through release
    add_null(0, 1, 0, 1);
    add_null(1, 1, 1, 1);
    add_null(1, 1, 1, 1);
    add     (1, 1, 0, 1, 8'h00, 8'hFE, 8'h01, 0, 0, 1);
    add_null(1, 1, 1, 1);
    // dut0 counting down, through 0 with borrow and wrap
    add     (1, 1, 0, 0, 8'h01, 8'hFF, 8'h00, 0, 1, 1);
    add_null(1, 1, 1, 0);
    add     (1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 1);
    add_null(1, 1, 1, 0);
    add     (1, 1, 0, 0, 8'hFF, 8'h01, 8'h00, 0, 0, 1);

    @(negedge clk);
    foreach (tbl[i]) apply(tbl[i]);

    // Hand sequence: return to NULL, idle with en low, then DATA must
    // appear exactly one edge after en rises.
    r = '0;
    r.init_n = 1'b1;
    r.ack    = 1'b1;
    apply(r);
    r.ack = 1'b0;
    for (int unsigned k = 0; k < 5; k++) apply(r);

    init_n   = 1'b1;
    en       = 1'b1;
    ack_comp = 1'b0;
    dir0     = 1'b1;
    r.en     = 1'b1;
    r.dir    = 1'b1;
    r.comp   = 1'b1;
    r.v[0]   = 8'hFE;
    r.v[1]   = 8'h02;
    r.v[2]   = 8'h00;
    r.c      = 3'b100;
    sbq.push_back(r);
    n = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (comp[0]) break;
    end
    checks++;
    if (!comp[0] || n != 1) begin
      errors++;
      $display("FAIL en_rise_latency: comp_out after %0d edges (comp=%b), required 1 edge", n, comp[0]);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
